// File: rtl/rr_arbiter8.sv
// Eight-way round-robin arbiter for a shared resource, with a bounded hold time.
// Grants are registered and always separated by one idle cycle.
module rr_arbiter8 #(
    parameter int unsigned MAX_HOLD = 15
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] req,
    input  logic       done,
    output logic [7:0] grant,
    output logic [2:0] grant_idx,
    output logic       busy,
    output logic       timeout
);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

    state_t     state_q, state_d;
    logic [2:0] ptr_q, ptr_d;
    logic [7:0] hold_cnt_q, hold_cnt_d;
    logic [7:0] grant_q, grant_d;
    logic [2:0] grant_idx_q, grant_idx_d;
    logic       busy_q, busy_d;
    logic       timeout_q, timeout_d;

    logic       found_s;
    logic [2:0] sel_s;
    logic       withdraw_s;
    logic       hold_hit_s;
    logic       release_s;

    // Rotating priority scan: first set request at or after ptr, wrapping 7->0.
    always_comb begin
        logic [2:0] cand;
        found_s = 1'b0;
        sel_s   = ptr_q;
        cand    = ptr_q;
        for (int i = 0; i < 8; i++) begin
            cand = ptr_q + 3'(i);
            if (!found_s && req[cand]) begin
                found_s = 1'b1;
                sel_s   = cand;
            end else begin
                found_s = found_s;
            end
        end
    end

    assign withdraw_s = ~req[grant_idx_q];
    assign hold_hit_s = (hold_cnt_q == HOLD_LAST);
    assign release_s  = done | withdraw_s | hold_hit_s;

    // Next-state and next-output logic.
    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        hold_cnt_d  = hold_cnt_q;
        grant_d     = grant_q;
        grant_idx_d = grant_idx_q;
        busy_d      = busy_q;
        timeout_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (found_s) begin
                    grant_d     = 8'd1 << sel_s;
                    grant_idx_d = sel_s;
                    busy_d      = 1'b1;
                    hold_cnt_d  = 8'd0;
                    state_d     = GRANT;
                end else begin
                    grant_d = 8'd0;
                    busy_d  = 1'b0;
                end
            end
            GRANT: begin
                if (release_s) begin
                    grant_d   = 8'd0;
                    busy_d    = 1'b0;
                    ptr_d     = grant_idx_q + 3'd1;
                    state_d   = IDLE;
                    // Timeout flags only a release forced purely by the hold limit.
                    timeout_d = hold_hit_s & ~done & ~withdraw_s;
                end else begin
                    hold_cnt_d = hold_cnt_q + 8'd1;
                end
            end
            default: begin
                state_d = IDLE;
                grant_d = 8'd0;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            ptr_q       <= 3'd0;
            hold_cnt_q  <= 8'd0;
            grant_q     <= 8'd0;
            grant_idx_q <= 3'd0;
            busy_q      <= 1'b0;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            hold_cnt_q  <= hold_cnt_d;
            grant_q     <= grant_d;
            grant_idx_q <= grant_idx_d;
            busy_q      <= busy_d;
            timeout_q   <= timeout_d;
        end
    end

    assign grant     = grant_q;
    assign grant_idx = grant_idx_q;
    assign busy      = busy_q;
    assign timeout   = timeout_q;

endmodule

// File: tb/tb_rr_arbiter8.sv
// Directed bench for rr_arbiter8: default-hold instance plus a MAX_HOLD=4 instance.
module tb_rr_arbiter8;

    logic       clk;
    logic       rst;
    logic [7:0] req;
    logic [7:0] req4;
    logic       done;
    logic [7:0] grant, grant4;
    logic [2:0] grant_idx, grant_idx4;
    logic       busy, busy4;
    logic       timeout, timeout4;

    int errors = 0;
    int checks = 0;

    rr_arbiter8 dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .done      (done),
        .grant     (grant),
        .grant_idx (grant_idx),
        .busy      (busy),
        .timeout   (timeout)
    );

    rr_arbiter8 #(.MAX_HOLD(4)) dut4 (
        .clk       (clk),
        .rst       (rst),
        .req       (req4),
        .done      (done),
        .grant     (grant4),
        .grant_idx (grant_idx4),
        .busy      (busy4),
        .timeout   (timeout4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic [7:0] g, input logic [2:0] idx,
                           input logic b, input logic t);
        chk({tag, ".grant"}, {24'd0, grant}, {24'd0, g});
        chk({tag, ".idx"}, {29'd0, grant_idx}, {29'd0, idx});
        chk({tag, ".busy"}, {31'd0, busy}, {31'd0, b});
        chk({tag, ".timeout"}, {31'd0, timeout}, {31'd0, t});
    endtask

    initial begin
        logic [7:0] eg;
        rst  = 1'b1;
        req  = 8'h00;
        req4 = 8'h00;
        done = 1'b0;
        tick();
        tick();
        chk_out("reset", 8'h00, 3'd0, 1'b0, 1'b0);
        chk("reset4.busy", {31'd0, busy4}, 32'd0);
        rst = 1'b0;

        // Two requesters 0 and 7, done on the third grant cycle.
        req = 8'h81;
        tick();
        chk_out("s27.first", 8'h01, 3'd0, 1'b1, 1'b0);
        tick();
        chk_out("s27.hold2", 8'h01, 3'd0, 1'b1, 1'b0);
        done = 1'b1;
        tick();
        chk_out("s27.release", 8'h00, 3'd0, 1'b0, 1'b0);
        done = 1'b0;
        tick();
        chk_out("s27.second", 8'h80, 3'd7, 1'b1, 1'b0);
        done = 1'b1;
        tick();
        chk_out("s27.release2", 8'h00, 3'd7, 1'b0, 1'b0);
        done = 1'b0;
        req  = 8'h00;
        tick();
        chk_out("idle.noreq", 8'h00, 3'd7, 1'b0, 1'b0);

        // All requesting, done every grant: pointer walks 0..7 then wraps.
        req = 8'hFF;
        for (int k = 0; k < 9; k++) begin
            tick();
            eg = 8'd1 << (k % 8);
            chk_out("s28.grant", eg, 3'(k % 8), 1'b1, 1'b0);
            done = 1'b1;
            tick();
            chk_out("s28.gap", 8'h00, 3'(k % 8), 1'b0, 1'b0);
            done = 1'b0;
        end
        req = 8'h00;
        tick();

        // Requester 5 granted, stays stable under other req changes, then withdraws.
        req = 8'h20;
        tick();
        chk_out("s30.grant", 8'h20, 3'd5, 1'b1, 1'b0);
        req = 8'h3F;
        tick();
        chk_out("s30.stable", 8'h20, 3'd5, 1'b1, 1'b0);
        req = 8'h1F;
        tick();
        chk_out("s30.withdraw", 8'h00, 3'd5, 1'b0, 1'b0);
        req = 8'hFF;
        tick();
        chk_out("s30.ptr6", 8'h40, 3'd6, 1'b1, 1'b0);

        // Hold until the last allowed cycle, then done coincides with the limit.
        for (int k = 0; k < 14; k++) begin
            tick();
        end
        chk_out("s32.held", 8'h40, 3'd6, 1'b1, 1'b0);
        done = 1'b1;
        tick();
        chk_out("s32.release", 8'h00, 3'd6, 1'b0, 1'b0);
        done = 1'b0;
        req  = 8'h00;
        tick();

        // Reset mid-grant; arbitration restarts from pointer 0.
        req = 8'h08;
        tick();
        chk_out("s31.grant", 8'h08, 3'd3, 1'b1, 1'b0);
        rst = 1'b1;
        tick();
        chk_out("s31.reset", 8'h00, 3'd0, 1'b0, 1'b0);
        rst = 1'b0;
        tick();
        chk_out("s31.regrant", 8'h08, 3'd3, 1'b1, 1'b0);
        req = 8'h00;
        tick();
        chk_out("s31.withdraw", 8'h00, 3'd3, 1'b0, 1'b0);

        // MAX_HOLD=4: grant held four cycles, timeout pulse, re-grant.
        req4 = 8'h04;
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("s29.grant", {24'd0, grant4}, 32'h04);
            chk("s29.busy", {31'd0, busy4}, 32'd1);
            chk("s29.to_low", {31'd0, timeout4}, 32'd0);
        end
        tick();
        chk("s29.rel_grant", {24'd0, grant4}, 32'h00);
        chk("s29.rel_busy", {31'd0, busy4}, 32'd0);
        chk("s29.timeout", {31'd0, timeout4}, 32'd1);
        tick();
        chk("s29.regrant", {24'd0, grant4}, 32'h04);
        chk("s29.reidx", {29'd0, grant_idx4}, 32'd2);
        chk("s29.to_pulse", {31'd0, timeout4}, 32'd0);
        req4 = 8'h00;
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/rr_arbiter8.md
RR_ARBITER8 -- requirements
Module: rr_arbiter8

Interface
REQ-001 Parameter: MAX_HOLD, default 15, maximum cycles a grant may be held before forced release; legal range 1..255.
REQ-002 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 Port: rst  input  1  reset, synchronous, active-high.
REQ-004 Port: req  input  8  request vector; bit i = requester i asks for the shared 8:3 encoder resource.
REQ-005 Port: done  input  1  current owner releases the resource this cycle.
REQ-006 Port: grant  output  8  one-hot grant vector, registered.
REQ-007 Port: grant_idx  output  3  binary index of the granted requester, registered; equals the 8:3 encoding of grant.
REQ-008 Port: busy  output  1  high while a grant is active.
REQ-009 Port: timeout  output  1  one-cycle pulse when a grant is force-released by the hold limit.

Function
REQ-010 The FSM SHALL have two states: IDLE and GRANT.
REQ-011 Internal state SHALL be: 3-bit round-robin pointer ptr; 8-bit hold counter hold_cnt.
REQ-012 In IDLE with req != 0, the block SHALL select the first set req bit scanning ptr, ptr+1, ..., wrapping 7->0.
REQ-013 On that edge it SHALL load grant (one-hot), grant_idx and busy=1, clear hold_cnt, and enter GRANT.
REQ-014 Grant latency SHALL be exactly 1 cycle: req sampled in IDLE at edge N gives grant visible after edge N.
REQ-015 In IDLE with req == 0, outputs SHALL stay grant=0, busy=0, and ptr SHALL be unchanged.
REQ-016 In GRANT, grant and grant_idx SHALL remain stable until release, regardless of other req changes.
REQ-017 Release SHALL occur on any of these conditions:
- done=1;
- req[grant_idx]=0 (requester withdraws);
- hold_cnt == MAX_HOLD-1.
REQ-018 On release the block SHALL:
- clear grant to 0 and busy to 0;
- set ptr = grant_idx+1 mod 8 (7 wraps to 0);
- return to IDLE.
grant_idx SHALL hold its last value.
REQ-019 After every release there SHALL be exactly one IDLE cycle before the next grant; no back-to-back grants.
REQ-020 hold_cnt SHALL increment by 1 each GRANT cycle that does not release; it SHALL never wrap.
REQ-021 timeout SHALL pulse 1 only when release is caused solely by the hold limit; done=1 or withdrawal in the same cycle suppresses timeout.
REQ-022 In any cycle, grant SHALL be zero or one-hot, and grant != 0 iff busy=1.
REQ-023 Within any 8 consecutive grants, a continuously-asserted requester SHALL receive at least one grant (starvation-free).

Reset
REQ-024 When rst=1 at a rising edge, the block SHALL set: state=IDLE, ptr=0, hold_cnt=0, grant=0, grant_idx=0, busy=0, timeout=0.
REQ-025 rst SHALL take priority over all other inputs, including mid-GRANT; no timeout pulse is produced by reset.
REQ-026 On the first edge after rst deasserts, arbitration SHALL start from ptr=0.

Verification
REQ-027 Scenario: after reset, req=8'b1000_0001 held -> first grant=8'h01/idx 0; done at cycle 3 -> next grant=8'h80/idx 7 after 1 idle cycle.
REQ-028 Scenario: req=8'hFF held, done pulsed every grant -> grant_idx sequence 0,1,2,...,7,0 with one idle cycle between grants.
REQ-029 Scenario: MAX_HOLD=4, req=8'h04 held, done=0:
- grant 8'h04 held exactly 4 cycles, then timeout=1 for one cycle and busy=0;
- re-grant of idx 2 one cycle later.
REQ-030 Scenario: grant idx 5 active, req[5] drops -> release next edge, timeout=0, ptr=6.
REQ-031 Scenario: rst=1 asserted mid-GRANT with idx 3 -> next edge grant=0, busy=0, grant_idx=0; then req=8'h08 -> grant idx 3 from ptr=0.
REQ-032 Scenario: done=1 and hold limit coincide -> release with timeout=0.
